acc_alu: RTL and testbench
==========================

# acc_alu

Parametrised accumulator ALU, the successor to the 4-bit combinational ALU. It keeps the same `ctrl` opcode encoding and adds an internal accumulator register as operand A, a start/busy/done handshake, and a multi-cycle shift-add multiply. It sits in the accumulator datapath: the control unit issues one operation at a time, and the accumulator value feeds back as the next A operand.

## Interface
- `WIDTH`, default 8: data width in bits (≥2); the accumulator and operand are both `WIDTH` bits.
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: issue the operation in `ctrl` using `operand`; sampled only while `busy`=0.
- `clear`, input, 1: synchronous clear of the accumulator and flags; highest priority after reset.
- `ctrl`, input, 4: opcode, sampled with `start`.
- `operand`, input, `WIDTH`: B operand, sampled with `start`.
- `acc`, output, `WIDTH`: accumulator register, also operand A.
- `ovr`, output, 1: registered overflow/carry flag of the last completed operation.
- `zero`, output, 1: combinational, `acc`==0.
- `busy`, output, 1: registered, high while a multiply is in progress.
- `done`, output, 1: registered, one-cycle pulse when an operation completes.

## Operation
- Opcodes (A=`acc`, B=`operand`, all unsigned; result written to `acc`):
  - 0000 AND: ovr=0.
  - 0001 OR: ovr=0.
  - 0010 ADD: {ovr,acc}=A+B in WIDTH+1 bits; ovr=carry out.
  - 0110 SUB: {ovr,acc}=A−B in WIDTH+1 bits; ovr=borrow (A<B).
  - 0111 SLT: acc=(A<B)?1:0; ovr=0.
  - 1100 NOR: ovr=0.
  - 1000 LOAD: acc=B; ovr=0.
  - 1010 SHL: acc=A<<1; ovr=A[WIDTH-1].
  - 1011 SHR: acc=A>>1 (logical); ovr=A[0].
  - 1001 MUL: 2·WIDTH-bit product A·B; acc=low half; ovr=1 if high half ≠0.
  - Any other opcode: acc=0, ovr=0, done still pulses.
- FSM has two states:
  - IDLE: busy=0. On `start`=1:
    - Single-cycle opcode: acc/ovr update at that edge; done=1 the next cycle.
    - MUL: latch A and B into internal multiplicand/multiplier registers, clear the 2·WIDTH product register, load the iteration counter with WIDTH, and go to MUL.
  - MUL: busy=1. Each edge performs one shift-add step (add the shifted multiplicand if the multiplier LSB is 1; shift the multiplier right) and decrements the counter.
    - At the final step, write acc/ovr, set done=1, and return to IDLE.
    - `acc` holds its old value until that final edge.
- `start` while `busy`=1 is ignored; no queuing.
- `clear`=1 at an edge: acc=0, ovr=0, done=0, state→IDLE, aborting any multiply with no done pulse. If `start` and `clear` are high together, `clear` wins and `start` is dropped.
- `zero` follows `acc` combinationally, including after `clear` and reset.

## Timing
- Reset (`rst_n`=0, asynchronous): acc=0, ovr=0, busy=0, done=0, state IDLE, counter and internal registers 0; therefore zero=1.
- Single-cycle ops: `start` at edge N → acc/ovr valid after edge N, done high for the cycle between edges N and N+1.
- MUL: `start` at edge N → busy high after edge N through edge N+WIDTH.
  - Result and done=1 appear after edge N+WIDTH; busy=0 in that same cycle.
  - Latency is WIDTH cycles.
- Back-to-back: a new `start` is accepted in the cycle done is high, since busy=0 then. A single-cycle op can therefore be issued every cycle.
- done is never high for two consecutive cycles except when two operations are issued back-to-back.
- Reset asserted mid-multiply: immediate return to reset values; no done pulse.

## Test plan
- Reset with WIDTH=8: deassert rst_n → acc=0, zero=1, busy=0, done=0. Assert rst_n asynchronously mid-cycle → outputs clear before the next edge.
- LOAD 200, then ADD 100 → acc=44, ovr=1, done pulses once per op. SUB 50 → acc=250, ovr=1. SLT 251 → acc=1, ovr=0.
- LOAD 0x81, SHL → acc=0x02, ovr=1. SHR → acc=0x01, ovr=0. NOR 0xF0 → acc=0x0E.
- LOAD 15, MUL 17 → busy high for exactly 8 cycles, then acc=255, ovr=0, done pulse. LOAD 16, MUL 16 → acc=0, ovr=1, zero=1.
- During MUL, pulse `start` with ADD → ignored, MUL result unchanged. `clear` at cycle 3 of a MUL → acc=0, busy=0, no done pulse. `start` and `clear` together → acc=0.
- Issue ADD 1 on 5 consecutive cycles from acc=0 → acc=5, done high for 5 consecutive cycles. Undefined opcode 1111 → acc=0, done pulses.

Source files
------------

// File: rtl/acc_alu_if.sv
// Bus between the control unit (master) and the accumulator ALU (slave).
//
// Handshake: the master raises start for one or more cycles with ctrl and
// operand valid alongside it; an edge with start=1 and busy=0 accepts the
// operation. start is ignored while busy=1; nothing is queued. done is a
// registered one-cycle pulse marking completion. clear at an edge overrides
// start and aborts any operation in progress without a done pulse.
// state_dbg mirrors the FSM state register (0 = idle, 1 = multiplying).
interface acc_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             clear;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc;
    logic             ovr;
    logic             zero;
    logic             busy;
    logic             done;
    logic             state_dbg;

    modport master (
        output start, clear, ctrl, operand,
        input  acc, ovr, zero, busy, done, state_dbg
    );

    modport slave (
        input  start, clear, ctrl, operand,
        output acc, ovr, zero, busy, done, state_dbg
    );
endinterface

// File: rtl/acc_alu.sv
// Accumulator ALU: the accumulator is operand A, the bus operand is B.
// Single-cycle ops update acc/ovr at the accepting edge; MUL runs a
// WIDTH-step shift-add sequence and writes acc/ovr at its final edge.
module acc_alu #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    acc_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1010;
    localparam logic [3:0] OP_SHR  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovr_q, ovr_d;
    logic             done_q, done_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             busy_o;
    logic             accept;
    logic             is_mul;
    logic             last_step;
    logic [PW-1:0]    step_sum;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovr;

    // An operation is taken only from idle, and clear always wins over start.
    assign accept    = (state_q == S_IDLE) && bus.start && !bus.clear;
    assign is_mul    = (bus.ctrl == OP_MUL);
    assign last_step = (cnt_q == CW'(1));
    assign step_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle ALU result; the WIDTH+1 bit sums give carry and borrow.
    always_comb begin
        add_w   = {1'b0, acc_q} + {1'b0, bus.operand};
        sub_w   = {1'b0, acc_q} - {1'b0, bus.operand};
        alu_res = '0;
        alu_ovr = 1'b0;
        case (bus.ctrl)
            OP_AND:  alu_res = acc_q & bus.operand;
            OP_OR:   alu_res = acc_q | bus.operand;
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_ovr = add_w[WIDTH];
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_ovr = sub_w[WIDTH];
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
            OP_NOR:  alu_res = ~(acc_q | bus.operand);
            OP_LOAD: alu_res = bus.operand;
            OP_SHL: begin
                alu_res = {acc_q[WIDTH-2:0], 1'b0};
                alu_ovr = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, acc_q[WIDTH-1:1]};
                alu_ovr = acc_q[0];
            end
            default: begin
                alu_res = '0;
                alu_ovr = 1'b0;
            end
        endcase
    end

    // Next state: enter MUL on an accepted multiply, leave on the last step or clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (bus.clear || last_step) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy is decoded straight from the state register.
    always_comb begin
        busy_o = (state_q == S_MUL);
    end

    // Datapath next values: clear, then accepted op, then multiply steps.
    always_comb begin
        acc_d    = acc_q;
        ovr_d    = ovr_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (bus.clear) begin
            acc_d = '0;
            ovr_d = 1'b0;
            cnt_d = '0;
        end else if (accept) begin
            if (is_mul) begin
                // acc keeps its old value until the final multiply edge
                mcand_d  = {{WIDTH{1'b0}}, acc_q};
                mplier_d = bus.operand;
                prod_d   = '0;
                cnt_d    = CW'(WIDTH);
            end else begin
                acc_d  = alu_res;
                ovr_d  = alu_ovr;
                done_d = 1'b1;
            end
        end else if (state_q == S_MUL) begin
            prod_d   = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (last_step) begin
                acc_d  = step_sum[WIDTH-1:0];
                ovr_d  = |step_sum[PW-1:WIDTH];
                done_d = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            ovr_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            ovr_q    <= ovr_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.acc       = acc_q;
    assign bus.ovr       = ovr_q;
    assign bus.zero      = (acc_q == '0);
    assign bus.busy      = busy_o;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_acc_alu.sv
// Bench for acc_alu: directed steps followed by random operations, each
// result predicted by an arithmetic reference model of the accumulator.
module tb_acc_alu;
    localparam int W = 8;
    localparam int M = 1 << W;

    localparam logic [3:0] AND_OP  = 4'b0000;
    localparam logic [3:0] OR_OP   = 4'b0001;
    localparam logic [3:0] ADD_OP  = 4'b0010;
    localparam logic [3:0] SUB_OP  = 4'b0110;
    localparam logic [3:0] SLT_OP  = 4'b0111;
    localparam logic [3:0] NOR_OP  = 4'b1100;
    localparam logic [3:0] LOAD_OP = 4'b1000;
    localparam logic [3:0] SHL_OP  = 4'b1010;
    localparam logic [3:0] SHR_OP  = 4'b1011;
    localparam logic [3:0] MUL_OP  = 4'b1001;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    acc_alu_if #(.WIDTH(W)) bus();

    acc_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state and expected-result queue
    int acc_m = 0;
    bit ovr_m = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Operation semantics from the opcode table, in plain integer arithmetic.
    function automatic void ref_op(input logic [3:0] op, input int a, input int b,
                                   output int r, output bit o);
        longint p;
        r = 0;
        o = 1'b0;
        case (op)
            AND_OP:  r = a & b;
            OR_OP:   r = a | b;
            ADD_OP: begin r = (a + b) % M; o = (a + b) >= M; end
            SUB_OP: begin r = (a - b + M) % M; o = a < b; end
            SLT_OP:  r = (a < b) ? 1 : 0;
            NOR_OP:  r = (M - 1) - (a | b);
            LOAD_OP: r = b;
            SHL_OP: begin r = (a * 2) % M; o = a >= M / 2; end
            SHR_OP: begin r = a / 2; o = (a % 2) == 1; end
            MUL_OP: begin
                p = longint'(a) * longint'(b);
                r = int'(p % M);
                o = p >= M;
            end
            default: begin r = 0; o = 1'b0; end
        endcase
    endfunction

    // driver: issue one operation, wait for completion, score it
    task automatic run_op(input logic [3:0] op, input int b);
        int r;
        bit o;
        int n;
        logic [W-1:0] exp_acc;
        ref_op(op, acc_m, b, r, o);
        exp_acc = r[W-1:0];
        exp_q.push_back(exp_acc);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.ctrl    = op;
        bus.operand = b[W-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        if (op == MUL_OP) begin
            n = 0;
            while (bus.busy === 1'b1 && n < 4 * W) begin
                n++;
                @(negedge clk);
            end
            chk("mul_busy_cycles", n, W);
        end
        chk($sformatf("op%0h_done", op), bus.done, 1);
        chk($sformatf("op%0h_busy", op), bus.busy, 0);
        chk($sformatf("op%0h_acc", op), bus.acc, exp_q.pop_front());
        chk($sformatf("op%0h_ovr", op), bus.ovr, o);
        chk($sformatf("op%0h_zero", op), bus.zero, r == 0);
        acc_m = r;
        ovr_m = o;
        @(negedge clk);
        chk($sformatf("op%0h_done_drop", op), bus.done, 0);
        chk($sformatf("op%0h_acc_hold", op), bus.acc, exp_acc);
    endtask

    initial begin
        logic [3:0] ops [12];
        bit seen_done;
        int n;
        ops = '{AND_OP, OR_OP, ADD_OP, SUB_OP, SLT_OP, NOR_OP, LOAD_OP,
                SHL_OP, SHR_OP, MUL_OP, 4'b0011, 4'b1111};
        bus.start   = 1'b0;
        bus.clear   = 1'b0;
        bus.ctrl    = 4'b0000;
        bus.operand = '0;

        // reset values
        #3;
        chk("rst_acc", bus.acc, 0);
        chk("rst_zero", bus.zero, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovr", bus.ovr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_acc", bus.acc, 0);
        chk("post_rst_zero", bus.zero, 1);

        // arithmetic plan
        run_op(LOAD_OP, 200);
        run_op(ADD_OP, 100);
        chk("plan_add_acc", bus.acc, 44);
        chk("plan_add_ovr", bus.ovr, 1);
        run_op(SUB_OP, 50);
        chk("plan_sub_acc", bus.acc, 250);
        chk("plan_sub_ovr", bus.ovr, 1);
        run_op(SLT_OP, 251);
        chk("plan_slt_acc", bus.acc, 1);
        chk("plan_slt_ovr", bus.ovr, 0);

        // shifts and NOR
        run_op(LOAD_OP, 8'h81);
        run_op(SHL_OP, 0);
        chk("plan_shl_acc", bus.acc, 8'h02);
        chk("plan_shl_ovr", bus.ovr, 1);
        run_op(SHR_OP, 0);
        chk("plan_shr_acc", bus.acc, 8'h01);
        chk("plan_shr_ovr", bus.ovr, 0);
        run_op(NOR_OP, 8'hF0);
        chk("plan_nor_acc", bus.acc, 8'h0E);

        // asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_acc", bus.acc, 0);
        chk("async_rst_zero", bus.zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = 0;
        ovr_m = 1'b0;

        // multiply
        run_op(LOAD_OP, 15);
        run_op(MUL_OP, 17);
        chk("plan_mul1_acc", bus.acc, 255);
        chk("plan_mul1_ovr", bus.ovr, 0);
        run_op(LOAD_OP, 16);
        run_op(MUL_OP, 16);
        chk("plan_mul2_acc", bus.acc, 0);
        chk("plan_mul2_ovr", bus.ovr, 1);
        chk("plan_mul2_zero", bus.zero, 1);

        // start during a multiply is ignored
        run_op(LOAD_OP, 13);
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = MUL_OP; bus.operand = 8'd11;
        @(negedge clk);
        bus.ctrl = ADD_OP; bus.operand = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 4 * W) begin
            n++;
            @(negedge clk);
        end
        chk("ignored_start_busy", n, W - 1);
        chk("ignored_start_done", bus.done, 1);
        chk("ignored_start_acc", bus.acc, 143);
        acc_m = 143;
        ovr_m = 1'b0;
        @(negedge clk);
        chk("ignored_start_acc_hold", bus.acc, 143);

        // clear during the third cycle of a multiply
        run_op(LOAD_OP, 9);
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = MUL_OP; bus.operand = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_mul_acc", bus.acc, 0);
        chk("clear_mul_busy", bus.busy, 0);
        chk("clear_mul_done", bus.done, 0);
        chk("clear_mul_zero", bus.zero, 1);
        seen_done = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        chk("clear_mul_no_done", seen_done, 0);
        acc_m = 0;
        ovr_m = 1'b0;

        // start and clear together
        run_op(LOAD_OP, 8'h55);
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = LOAD_OP; bus.operand = 8'd7; bus.clear = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.clear = 1'b0;
        chk("start_clear_acc", bus.acc, 0);
        chk("start_clear_done", bus.done, 0);
        chk("start_clear_zero", bus.zero, 1);

        // asynchronous reset mid-multiply
        run_op(LOAD_OP, 200);
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = MUL_OP; bus.operand = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mul_busy", bus.busy, 0);
        chk("rst_mul_acc", bus.acc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        chk("rst_mul_no_done", seen_done, 0);
        acc_m = 0;
        ovr_m = 1'b0;

        // five back-to-back ADD 1 from acc=0
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = ADD_OP; bus.operand = 8'd1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 5) bus.start = 1'b0;
            chk($sformatf("b2b_done_%0d", i), bus.done, 1);
            chk($sformatf("b2b_acc_%0d", i), bus.acc, i);
        end
        @(negedge clk);
        chk("b2b_done_end", bus.done, 0);
        chk("b2b_acc_end", bus.acc, 5);
        acc_m = 5;
        ovr_m = 1'b0;

        // undefined opcode
        run_op(LOAD_OP, 8'h33);
        run_op(4'b1111, 8'h44);
        chk("undef_acc", bus.acc, 0);

        // random operations against the model
        for (int k = 0; k < 40; k++) begin
            run_op(ops[$urandom_range(0, 11)], int'($urandom_range(0, M - 1)));
        end

        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
